// File: rtl/crossclock_pkg.sv
// Shared types and helpers for the crossclock handshake receiver.
// Optional watchdog is enabled by defining CROSSCLOCK_HANDSHAKE_RX_TIMEOUT_EN.
package crossclock_pkg;

   typedef enum logic [1:0] {
      CH_IDLE = 2'd0,
      CH_FULL = 2'd1,
      CH_ACK  = 2'd2
   } ch_state_t;

   localparam int DEFAULT_SYNC_STAGES = 2;

   // Index width that never collapses to zero for a single-entry range.
   function automatic int clog2_min1(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/crossclock_rx_channel.sv
// One handshake channel: req synchroniser, capture FSM, hold register and ack flop.
// Watchdog counter and sticky error exist only with CROSSCLOCK_HANDSHAKE_RX_TIMEOUT_EN.
module crossclock_rx_channel
   import crossclock_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES
`ifdef CROSSCLOCK_HANDSHAKE_RX_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             async_req,
   input  logic [WIDTH-1:0] async_data,
   input  logic             grant,
`ifdef CROSSCLOCK_HANDSHAKE_RX_TIMEOUT_EN
   input  logic             err_clear,
   output logic             err_timeout,
`endif
   output logic             full,
   output logic             active,
   output logic             ack,
   output logic [WIDTH-1:0] hold
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sreq;
   ch_state_t              state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], async_req};
   end

   assign sreq = sync_q[SYNC_STAGES-1];

   // Payload is sampled only once sreq is seen, so the sender has held it
   // stable for at least SYNC_STAGES cycles.
   always_ff @(posedge clk) begin
      if (state == CH_IDLE && sreq) hold <= async_data;
   end

`ifdef CROSSCLOCK_HANDSHAKE_RX_TIMEOUT_EN
   localparam int TW = clog2_min1(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wd_cnt;
   logic          wd_fire;

   assign wd_fire = (state == CH_ACK) && sreq && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       err_timeout <= 1'b0;
      else if (wd_fire)   err_timeout <= 1'b1;
      else if (err_clear) err_timeout <= 1'b0;
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= CH_IDLE;
         ack   <= 1'b0;
`ifdef CROSSCLOCK_HANDSHAKE_RX_TIMEOUT_EN
         wd_cnt <= '0;
`endif
      end else begin
         case (state)
            CH_IDLE: begin
               ack <= 1'b0;
               if (sreq) state <= CH_FULL;
            end
            CH_FULL: begin
               if (grant) begin
                  state <= CH_ACK;
                  ack   <= 1'b1;
`ifdef CROSSCLOCK_HANDSHAKE_RX_TIMEOUT_EN
                  wd_cnt <= '0;
`endif
               end
            end
            CH_ACK: begin
               if (!sreq) begin
                  state <= CH_IDLE;
                  ack   <= 1'b0;
`ifdef CROSSCLOCK_HANDSHAKE_RX_TIMEOUT_EN
               end else if (wd_fire) begin
                  state <= CH_IDLE;
                  ack   <= 1'b0;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
`endif
               end
            end
            default: begin
               state <= CH_IDLE;
               ack   <= 1'b0;
            end
         endcase
      end
   end

   assign full   = (state == CH_FULL);
   assign active = (state != CH_IDLE);

endmodule

// File: rtl/crossclock_handshake_rx.sv
// Multi-channel 4-phase handshake receiver merged into one valid/ready stream.
// Define CROSSCLOCK_HANDSHAKE_RX_TIMEOUT_EN to add the per-channel ACK watchdog.
module crossclock_handshake_rx
   import crossclock_pkg::*;
#(
   parameter int CHANNELS       = 4,
   parameter int WIDTH          = 8,
   parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [CHANNELS-1:0]             async_req,
   input  logic [CHANNELS*WIDTH-1:0]       async_data,
   output logic [CHANNELS-1:0]             async_ack,
   output logic                            out_valid,
   output logic [WIDTH-1:0]                out_data,
   output logic [clog2_min1(CHANNELS)-1:0] out_chan,
   input  logic                            out_ready,
`ifdef CROSSCLOCK_HANDSHAKE_RX_TIMEOUT_EN
   output logic [CHANNELS-1:0]             err_timeout,
   input  logic                            err_clear,
`endif
   output logic                            busy
);

   localparam int CW = clog2_min1(CHANNELS);

   if (CHANNELS < 1 || CHANNELS > 16 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
       TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("crossclock_handshake_rx: parameter out of range");
   end

   logic [CHANNELS-1:0]       full;
   logic [CHANNELS-1:0]       active;
   logic [CHANNELS-1:0]       grant_vec;
   logic [CHANNELS*WIDTH-1:0] hold_bus;
   logic [CW-1:0]             rr_ptr;
   logic [CW-1:0]             gnt_idx;
   logic                      any_full;
   logic                      load_en;
   logic                      take;
   int                        idx;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      crossclock_rx_channel #(
         .WIDTH          (WIDTH),
         .SYNC_STAGES    (SYNC_STAGES)
`ifdef CROSSCLOCK_HANDSHAKE_RX_TIMEOUT_EN
         ,
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
      ) u_ch (
         .clk         (clk),
         .reset_n     (reset_n),
         .async_req   (async_req[i]),
         .async_data  (async_data[i*WIDTH +: WIDTH]),
         .grant       (grant_vec[i]),
`ifdef CROSSCLOCK_HANDSHAKE_RX_TIMEOUT_EN
         .err_clear   (err_clear),
         .err_timeout (err_timeout[i]),
`endif
         .full        (full[i]),
         .active      (active[i]),
         .ack         (async_ack[i]),
         .hold        (hold_bus[i*WIDTH +: WIDTH])
      );
   end

   // Round-robin search: first FULL channel at or after rr_ptr, wrapping.
   always_comb begin
      any_full = 1'b0;
      gnt_idx  = '0;
      idx      = 0;
      for (int k = 0; k < CHANNELS; k++) begin
         idx = (int'(rr_ptr) + k) % CHANNELS;
         if (!any_full && full[idx]) begin
            any_full = 1'b1;
            gnt_idx  = CW'(idx);
         end
      end
   end

   assign load_en = !out_valid || out_ready;
   assign take    = load_en && any_full;

   always_comb begin
      grant_vec = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         grant_vec[i] = take && (gnt_idx == CW'(i));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         rr_ptr    <= '0;
      end else if (take) begin
         out_valid <= 1'b1;
         out_data  <= hold_bus[int'(gnt_idx)*WIDTH +: WIDTH];
         out_chan  <= gnt_idx;
         rr_ptr    <= (gnt_idx == CW'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign busy = (|active) || out_valid;

endmodule

// File: tb/tb_crossclock_handshake_rx.sv
// Directed bench for crossclock_handshake_rx (4 channels, 8-bit payload, 2 sync stages).
module tb_crossclock_handshake_rx;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  async_req;
   logic [31:0] async_data;
   logic [3:0]  async_ack;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_chan;
   logic        out_ready;
   logic        busy;
`ifdef CROSSCLOCK_HANDSHAKE_RX_TIMEOUT_EN
   logic [3:0]  err_timeout;
   logic        err_clear;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   crossclock_handshake_rx #(
      .CHANNELS       (4),
      .WIDTH          (8),
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .async_req   (async_req),
      .async_data  (async_data),
      .async_ack   (async_ack),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_chan    (out_chan),
      .out_ready   (out_ready),
`ifdef CROSSCLOCK_HANDSHAKE_RX_TIMEOUT_EN
      .err_timeout (err_timeout),
      .err_clear   (err_clear),
`endif
      .busy        (busy)
   );

   typedef struct {
      int         chan;
      logic [7:0] data;
      logic [7:0] exp_data;
      logic [1:0] exp_chan;
      logic [3:0] exp_ack;
   } vec_t;

   vec_t tbl[4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      async_req = '0;
      tick(2);
      reset_n = 1'b1;
      tick(1);
   endtask

   int words;

   initial begin
      reset_n    = 1'b0;
      async_req  = '0;
      async_data = '0;
      out_ready  = 1'b1;
`ifdef CROSSCLOCK_HANDSHAKE_RX_TIMEOUT_EN
      err_clear  = 1'b0;
`endif
      tbl[0] = '{chan: 2, data: 8'hA5, exp_data: 8'hA5, exp_chan: 2'd2, exp_ack: 4'b0100};
      tbl[1] = '{chan: 0, data: 8'h3C, exp_data: 8'h3C, exp_chan: 2'd0, exp_ack: 4'b0001};
      tbl[2] = '{chan: 3, data: 8'hFF, exp_data: 8'hFF, exp_chan: 2'd3, exp_ack: 4'b1000};
      tbl[3] = '{chan: 1, data: 8'h00, exp_data: 8'h00, exp_chan: 2'd1, exp_ack: 4'b0010};

      #1;
      chk("reset out_valid", out_valid, 0);
      chk("reset ack", async_ack, 0);
      chk("reset busy", busy, 0);
      chk("reset out_data", out_data, 0);
      chk("reset out_chan", out_chan, 0);
      tick(2);
      reset_n = 1'b1;
      tick(1);

      // Single transfers, one per table entry
      for (int v = 0; v < 4; v++) begin
         async_data = 32'h5A5A5A5A;
         async_data[tbl[v].chan*8 +: 8] = tbl[v].data;
         async_req[tbl[v].chan] = 1'b1;
         tick(3);
         chk("single early valid", out_valid, 0);
         tick(1);
         chk("single valid", out_valid, 1);
         chk("single data", out_data, tbl[v].exp_data);
         chk("single chan", out_chan, tbl[v].exp_chan);
         chk("single ack", async_ack, tbl[v].exp_ack);
         tick(1);
         chk("single one-cycle", out_valid, 0);
         async_req = '0;
         tick(2);
         chk("single ack held", async_ack, tbl[v].exp_ack);
         tick(1);
         chk("single ack low", async_ack, 0);
         chk("single busy low", busy, 0);
      end

      // All four at once
      do_reset();
      async_data = 32'h13121110;
      async_req  = 4'hF;
      tick(4);
      for (int c = 0; c < 4; c++) begin
         chk("rr valid", out_valid, 1);
         chk("rr chan", out_chan, c);
         chk("rr data", out_data, 32'h10 + c);
         tick(1);
      end
      chk("rr drained", out_valid, 0);
      chk("rr all ack", async_ack, 4'hF);
      async_req = '0;
      tick(4);
      chk("rr ack low", async_ack, 0);
      chk("rr busy low", busy, 0);

      // Backpressure with channels 0 and 1
      do_reset();
      out_ready  = 1'b0;
      async_data = 32'h00006655;
      async_req  = 4'b0011;
      tick(4);
      chk("bp first valid", out_valid, 1);
      for (int t = 0; t < 20; t++) begin
         if (out_data !== 8'h55 || out_chan !== 2'd0 || async_ack[1] !== 1'b0) break;
         tick(1);
      end
      chk("bp held data", out_data, 8'h55);
      chk("bp held chan", out_chan, 0);
      chk("bp ch1 no ack", async_ack[1], 0);
      chk("bp ch0 ack", async_ack[0], 1);
      chk("bp busy", busy, 1);
      out_ready = 1'b1;
      tick(1);
      chk("bp release valid", out_valid, 1);
      chk("bp release data", out_data, 8'h66);
      chk("bp release chan", out_chan, 1);
      chk("bp release ack1", async_ack[1], 1);
      tick(1);
      chk("bp drained", out_valid, 0);
      async_req = '0;
      tick(4);

      // Held req gives a single word; re-raise gives a second
      do_reset();
      async_data = 32'h00007700;
      async_req  = 4'b0010;
      words = 0;
      for (int t = 0; t < 16; t++) begin
         tick(1);
         if (out_valid) words++;
      end
      chk("held one word", words, 1);
      chk("held ack", async_ack, 4'b0010);
      async_req = '0;
      tick(3);
      chk("held ack low", async_ack, 0);
      async_data = 32'h00008800;
      async_req  = 4'b0010;
      tick(4);
      chk("rereq valid", out_valid, 1);
      chk("rereq data", out_data, 8'h88);
      async_req = '0;
      tick(4);

      // Reset in the middle of a handshake
      do_reset();
      out_ready  = 1'b0;
      async_data = 32'h99000000;
      async_req  = 4'b1000;
      tick(6);
      chk("mid ack before", async_ack, 4'b1000);
      chk("mid valid before", out_valid, 1);
      reset_n = 1'b0;
      #1;
      chk("mid async ack", async_ack, 0);
      chk("mid async valid", out_valid, 0);
      chk("mid async busy", busy, 0);
      async_req = '0;
      tick(2);
      reset_n   = 1'b1;
      out_ready = 1'b1;
      words = 0;
      for (int t = 0; t < 10; t++) begin
         tick(1);
         if (out_valid) words++;
      end
      chk("mid no ghost", words, 0);
      async_data = 32'h42000000;
      async_req  = 4'b1000;
      tick(4);
      chk("mid new word", out_data, 8'h42);
      chk("mid new valid", out_valid, 1);
      async_req = '0;
      tick(4);

`ifdef CROSSCLOCK_HANDSHAKE_RX_TIMEOUT_EN
      // Watchdog: ack rises, then 16 cycles later it is forced low
      do_reset();
      async_data = 32'h000000E1;
      async_req  = 4'b0001;
      tick(4);
      chk("wd ack up", async_ack[0], 1);
      tick(15);
      chk("wd not yet", err_timeout[0], 0);
      chk("wd ack still", async_ack[0], 1);
      tick(1);
      chk("wd err set", err_timeout[0], 1);
      chk("wd ack dropped", async_ack[0], 0);
      async_req = '0;
      err_clear = 1'b1;
      tick(1);
      err_clear = 1'b0;
      chk("wd err cleared", err_timeout[0], 0);
      tick(6);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
